mem_controller: RTL and testbench

Parametrised memory controller sitting between the processor's load/store and fetch path and the ROM and read/write memory arrays. It replaces combinational address-range enable decoding with a registered request/response handshake. It adds per-region wait states, byte-enabled writes, a single registered read-data mux (no shared output bus), and fault reporting for unmapped, misaligned or ROM-write accesses.

---
 rtl/mem_controller.sv | 159 +++++++++++++++
 tb/tb_mem_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_controller.sv
// rtl/mem_controller.sv - registered request/response controller for the ROM and RAM arrays
// Decodes each accepted request once, strobes the target for one cycle, waits, then returns a held response.
module mem_controller #(
   parameter int ADDR_W   = 32,
   parameter int ROM_END  = 64000,
   parameter int RAM_END  = 131072,
   parameter int ROM_WAIT = 1,
   parameter int RAM_WAIT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_fault,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [3:0]        ram_be,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   localparam logic [ADDR_W-1:0] LP_ROM_END  = ADDR_W'(ROM_END);
   localparam logic [ADDR_W-1:0] LP_RAM_END  = ADDR_W'(RAM_END);
   localparam logic [3:0]        LP_ROM_WAIT = 4'(ROM_WAIT);
   localparam logic [3:0]        LP_RAM_WAIT = 4'(RAM_WAIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCESS,
      S_WAIT,
      S_CAPTURE,
      S_RESP
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic              r_write;
   logic              r_is_rom;
   logic [3:0]        r_wait_cnt;
   logic              r_rsp_valid;
   logic [31:0]       r_rsp_rdata;
   logic              r_rsp_fault;
   logic              r_rom_en;
   logic [ADDR_W-1:0] r_rom_addr;
   logic              r_ram_en;
   logic              r_ram_we;
   logic [3:0]        r_ram_be;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [31:0]       r_ram_wdata;

   logic              w_accept;
   logic              w_is_rom;
   logic              w_fault;
   logic [3:0]        w_acc_wait;

   always_comb begin
      w_accept     = req_valid && (r_state == S_IDLE);
      w_is_rom     = req_addr < LP_ROM_END;
      w_fault      = (req_addr[1:0] != 2'b00) || (req_addr >= LP_RAM_END) || (req_write && w_is_rom);
      w_acc_wait   = r_is_rom ? LP_ROM_WAIT : LP_RAM_WAIT;
      w_state_next = r_state;
      case (r_state)
         S_IDLE:    if (w_accept) w_state_next = w_fault ? S_RESP : S_ACCESS;
         S_ACCESS:  w_state_next = (w_acc_wait != 4'd0) ? S_WAIT : S_CAPTURE;
         S_WAIT:    if (r_wait_cnt == 4'd1) w_state_next = S_CAPTURE;
         S_CAPTURE: w_state_next = S_RESP;
         S_RESP:    if (rsp_ready) w_state_next = S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Strobes default low every cycle so each one is a single-cycle pulse issued from the accept edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_write     <= 1'b0;
         r_is_rom    <= 1'b0;
         r_wait_cnt  <= 4'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_rsp_fault <= 1'b0;
         r_rom_en    <= 1'b0;
         r_rom_addr  <= '0;
         r_ram_en    <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_be    <= 4'd0;
         r_ram_addr  <= '0;
         r_ram_wdata <= 32'd0;
      end else begin
         r_rom_en <= 1'b0;
         r_ram_en <= 1'b0;
         r_ram_we <= 1'b0;
         r_ram_be <= 4'd0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_write  <= req_write;
                  r_is_rom <= w_is_rom;
                  if (w_fault) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_fault <= 1'b1;
                     r_rsp_rdata <= 32'd0;
                  end else if (w_is_rom) begin
                     r_rom_en   <= 1'b1;
                     r_rom_addr <= req_addr;
                  end else begin
                     r_ram_en   <= 1'b1;
                     r_ram_we   <= req_write;
                     r_ram_be   <= req_write ? req_be : 4'd0;
                     r_ram_addr <= req_addr;
                     if (req_write) r_ram_wdata <= req_wdata;
                  end
               end
            end
            S_ACCESS: r_wait_cnt <= w_acc_wait;
            S_WAIT:   r_wait_cnt <= r_wait_cnt - 4'd1;
            S_CAPTURE: begin
               r_rsp_rdata <= r_write ? 32'd0 : (r_is_rom ? rom_rdata : ram_rdata);
               r_rsp_fault <= 1'b0;
               r_rsp_valid <= 1'b1;
            end
            S_RESP:   if (rsp_ready) r_rsp_valid <= 1'b0;
            default:  r_rsp_valid <= 1'b0;
         endcase
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_fault = r_rsp_fault;
   assign rom_en    = r_rom_en;
   assign rom_addr  = r_rom_addr;
   assign ram_en    = r_ram_en;
   assign ram_we    = r_ram_we;
   assign ram_be    = r_ram_be;
   assign ram_addr  = r_ram_addr;
   assign ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_mem_controller.sv
// tb/tb_mem_controller.sv - directed and random checks of mem_controller against a transaction-level model
// Memory devices and the expected-response model live here; expectations come from address-map rules.
module tb_mem_controller;

   localparam int ADDR_W   = 32;
   localparam int ROM_END  = 64000;
   localparam int RAM_END  = 131072;
   localparam int ROM_WAIT = 1;
   localparam int RAM_WAIT = 0;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic        rom_en;
   logic [31:0] rom_addr;
   logic [31:0] rom_rdata;
   logic        ram_en;
   logic        ram_we;
   logic [3:0]  ram_be;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   int errors = 0;
   int checks = 0;

   bit [31:0] ram_dev [bit [31:0]];
   bit [31:0] shadow  [bit [31:0]];

   always #5 clk = ~clk;

   mem_controller #(
      .ADDR_W(ADDR_W), .ROM_END(ROM_END), .RAM_END(RAM_END),
      .ROM_WAIT(ROM_WAIT), .RAM_WAIT(RAM_WAIT)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      if (a == 32'h10) return 32'hE3A00001;
      return (a ^ 32'h5A5A0000) * 32'h01000193 + 32'h1234;
   endfunction

   always @(posedge clk) begin : devices
      bit [31:0] w;
      if (rom_en) rom_rdata <= rom_word(rom_addr);
      if (ram_en) begin
         w = ram_dev.exists(ram_addr >> 2) ? ram_dev[ram_addr >> 2] : 32'd0;
         if (ram_we) begin
            for (int i = 0; i < 4; i++) if (ram_be[i]) w[8*i +: 8] = ram_wdata[8*i +: 8];
            ram_dev[ram_addr >> 2] = w;
         end else begin
            ram_rdata <= w;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string p);
      chk({p, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({p, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({p, "_rsp_fault"}, 32'(rsp_fault), 32'd0);
      chk({p, "_rsp_rdata"}, rsp_rdata, 32'd0);
      chk({p, "_strobes"}, {29'd0, rom_en, ram_en, ram_we}, 32'd0);
      chk({p, "_ram_be"}, 32'(ram_be), 32'd0);
      chk({p, "_rom_addr"}, rom_addr, 32'd0);
      chk({p, "_ram_addr"}, ram_addr, 32'd0);
      chk({p, "_ram_wdata"}, ram_wdata, 32'd0);
   endtask

   task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input int hold);
      bit e_fault, e_rom;
      int e_lat, lat, rom_cnt, ram_cnt, we_cnt, strobe_n, both;
      logic [31:0] e_rdata, m, addr_seen, wd_seen;
      logic [3:0] be_seen;
      e_rom   = a < 32'(ROM_END);
      e_fault = (a[1:0] != 2'b00) || (a >= 32'(RAM_END)) || (w && e_rom);
      e_lat   = e_fault ? 0 : 2 + (e_rom ? ROM_WAIT : RAM_WAIT);
      if (e_fault || w) e_rdata = 32'd0;
      else if (e_rom)   e_rdata = rom_word(a);
      else              e_rdata = shadow.exists(a >> 2) ? shadow[a >> 2] : 32'd0;
      if (!e_fault && w) begin
         m = shadow.exists(a >> 2) ? shadow[a >> 2] : 32'd0;
         for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = wd[8*i +: 8];
         shadow[a >> 2] = m;
      end
      lat = -1; rom_cnt = 0; ram_cnt = 0; we_cnt = 0; strobe_n = -1; both = 0;
      addr_seen = 0; wd_seen = 0; be_seen = 0;

      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_be = be;
      chk("ready_before_accept", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      // Keep valid asserted with junk payload: it must be ignored until IDLE.
      req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (rom_en && ram_en) both++;
         if (rom_en) begin rom_cnt++; strobe_n = n; addr_seen = rom_addr; end
         if (ram_en) begin
            ram_cnt++; strobe_n = n; addr_seen = ram_addr; be_seen = ram_be; wd_seen = ram_wdata;
            if (ram_we) we_cnt++;
         end
         if (rsp_valid) begin lat = n; break; end
      end
      req_valid = 1'b0;
      chk("latency", 32'(lat), 32'(e_lat));
      chk("rsp_fault", 32'(rsp_fault), 32'(e_fault));
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rom_en_count", 32'(rom_cnt), (e_rom && !e_fault) ? 32'd1 : 32'd0);
      chk("ram_en_count", 32'(ram_cnt), (!e_rom && !e_fault) ? 32'd1 : 32'd0);
      chk("ram_we_count", 32'(we_cnt), (!e_rom && !e_fault && w) ? 32'd1 : 32'd0);
      chk("strobe_overlap", 32'(both), 32'd0);
      chk("strobe_cycle", 32'(strobe_n), e_fault ? 32'hFFFFFFFF : 32'd0);
      if (!e_fault) chk("strobe_addr", addr_seen, a);
      if (!e_fault && !e_rom) chk("ram_be", 32'(be_seen), w ? 32'(be) : 32'd0);
      if (!e_fault && !e_rom && w) chk("ram_wdata", wd_seen, wd);
      if (lat >= 0) begin
         for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, e_rdata);
            chk("hold_fault", 32'(rsp_fault), 32'(e_fault));
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_strobes", {30'd0, rom_en, ram_en}, 32'd0);
         end
         rsp_ready = 1'b1;
         @(posedge clk);
         #1 rsp_ready = 1'b0;
         @(negedge clk);
         chk("post_hs_valid", 32'(rsp_valid), 32'd0);
         chk("post_hs_ready", 32'(req_ready), 32'd1);
      end
   endtask

   initial begin
      logic [31:0] a;
      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 0; req_wdata = 0;
      req_be = 0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b1;

      do_txn(1'b0, 32'h10, 32'd0, 4'hF, 0);
      do_txn(1'b1, 32'd64000, 32'hDEADBEEF, 4'b0011, 1);
      do_txn(1'b0, 32'd64000, 32'd0, 4'h0, 0);
      do_txn(1'b1, 32'h100, 32'h11112222, 4'hF, 0);
      do_txn(1'b0, 32'd131072, 32'd0, 4'hF, 0);
      do_txn(1'b0, 32'h2, 32'd0, 4'hF, 0);
      do_txn(1'b0, 32'h40, 32'd0, 4'hF, 5);
      do_txn(1'b0, 32'(ROM_END - 4), 32'd0, 4'hF, 0);
      do_txn(1'b1, 32'(RAM_END - 4), 32'hCAFEF00D, 4'hF, 0);
      do_txn(1'b0, 32'(RAM_END - 4), 32'd0, 4'hF, 2);
      do_txn(1'b0, 32'hFFFFFFFF, 32'd0, 4'hF, 0);
      do_txn(1'b0, 32'hFFFFFFFC, 32'd0, 4'hF, 0);
      do_txn(1'b1, 32'd64004, 32'h55667788, 4'b0000, 0);
      do_txn(1'b0, 32'd64004, 32'd0, 4'hF, 0);

      // Abandon a ROM read while it sits in its wait cycle.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_be = 4'hF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("after_reset_no_rsp", {29'd0, rsp_valid, rom_en, ram_en}, 32'd0);
      end
      do_txn(1'b0, 32'd64000, 32'd0, 4'hF, 0);

      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 5))
            0: a = 32'($urandom_range(0, ROM_END / 4 - 1)) << 2;
            1, 2: a = 32'(ROM_END) + (32'($urandom_range(0, 15)) << 2);
            3: begin a = $urandom; if (a[1:0] == 2'b00) a[0] = 1'b1; end
            4: a = 32'(RAM_END) + (32'($urandom_range(0, 100)) << 2);
            default: case ($urandom_range(0, 4))
               0: a = 32'(ROM_END - 4);
               1: a = 32'(ROM_END);
               2: a = 32'(RAM_END - 4);
               3: a = 32'(RAM_END);
               default: a = 32'hFFFFFFFF;
            endcase
         endcase
         do_txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
